// File: rtl/ps2_kb_ram_writer.sv
// ps2_kb_ram_writer: PS/2 keyboard deframer that writes accepted make codes into a circular RAM buffer
module ps2_kb_ram_writer #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic             ram_ena,
  output logic             wena,
  output logic [DEPTH-1:0] addr,
  output logic [WIDTH-1:0] data_in,
  output logic             frame_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, WRITE} state_t;
  state_t           state_q, state_d;
  logic [2:0]       kclk_q;
  logic [1:0]       kdat_q;
  logic [WIDTH-1:0] sr_q, sr_d, dat_q, dat_d;
  logic [2:0]       bcnt_q, bcnt_d;
  logic             par_q, par_d, brk_q, brk_d, ext_q, ext_d, err_q, err_d;
  logic [DEPTH-1:0] ptr_q, ptr_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             fe, dbit, in_frame, valid;
  assign fe       = kclk_q[2] & ~kclk_q[1];
  assign dbit     = kdat_q[1];
  assign in_frame = (state_q == DATA) || (state_q == PARITY) || (state_q == STOP);
  assign valid    = (^{sr_q, par_q}) & dbit;
  assign ram_ena  = (state_q == WRITE);
  assign wena     = ram_ena;
  assign addr     = ptr_q;
  assign data_in  = dat_q;
  assign frame_err = err_q;
  // Two-flop synchronisers; the third clock flop provides the falling-edge history. Idle lines are high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kclk_q <= '1;
      kdat_q <= '1;
    end else begin
      kclk_q <= {kclk_q[1:0], ps2_clk};
      kdat_q <= {kdat_q[0], ps2_data};
    end
  end
  // Frame, filter, pointer and timeout state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      dat_q   <= '0;
      bcnt_q  <= '0;
      par_q   <= 1'b0;
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      err_q   <= 1'b0;
      ptr_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      dat_q   <= dat_d;
      bcnt_q  <= bcnt_d;
      par_q   <= par_d;
      brk_q   <= brk_d;
      ext_q   <= ext_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
      tcnt_q  <= tcnt_d;
    end
  end
  // Next-state logic: deframing on falling edges, make-code filtering, single-cycle write, timeout abort.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    dat_d   = dat_q;
    bcnt_d  = bcnt_q;
    par_d   = par_q;
    brk_d   = brk_q;
    ext_d   = ext_q;
    err_d   = 1'b0;
    ptr_d   = ptr_q;
    tcnt_d  = (fe || !in_frame) ? '0 : tcnt_q + 1'b1;
    case (state_q)
      IDLE: if (fe && !dbit) begin
        state_d = DATA;
        bcnt_d  = '0;
      end
      DATA: if (fe) begin
        sr_d    = {dbit, sr_q[WIDTH-1:1]};
        bcnt_d  = bcnt_q + 3'd1;
        state_d = (bcnt_q == 3'd7) ? PARITY : DATA;
      end
      PARITY: if (fe) begin
        par_d   = dbit;
        state_d = STOP;
      end
      STOP: if (fe) begin
        state_d = IDLE;
        if (!valid) err_d = 1'b1;
        else if (sr_q == WIDTH'('hF0)) brk_d = 1'b1;
        else if (sr_q == WIDTH'('hE0)) ext_d = 1'b1;
        else if (brk_q) begin
          brk_d = 1'b0;
          ext_d = 1'b0;
        end else begin
          ext_d   = 1'b0;
          dat_d   = sr_q;
          state_d = WRITE;
        end
      end
      WRITE: begin
        ptr_d   = (ptr_q == {{(DEPTH-1){1'b1}}, 1'b0}) ? '0 : ptr_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (in_frame && !fe && tcnt_q == TW'(TIMEOUT - 2)) begin
      state_d = IDLE;
      err_d   = 1'b1;
      tcnt_d  = '0;
    end
  end
endmodule

// File: tb/tb_ps2_kb_ram_writer.sv
// tb_ps2_kb_ram_writer: directed, table-driven check of PS/2 deframing, filtering, writes, errors and wrap
module tb_ps2_kb_ram_writer;
  localparam int TO = 100;
  localparam int H  = 6;
  logic clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic ram_ena, wena, frame_err;
  logic [7:0] addr, data_in;
  int errors = 0, checks = 0;
  int nw = 0, ne = 0, ffseen = 0, wmis = 0, wa = -1;
  ps2_kb_ram_writer #(.WIDTH(8), .DEPTH(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ram_ena(ram_ena), .wena(wena), .addr(addr), .data_in(data_in), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  // Cycle monitor: counts write and error cycles, remembers the last write address.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_ena) begin
        nw <= nw + 1;
        wa <= int'(addr);
      end
      if (frame_err) ne <= ne + 1;
      if (addr == 8'hFF) ffseen <= ffseen + 1;
      if (wena !== ram_ena) wmis <= wmis + 1;
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask
  task automatic send_frame(input logic [7:0] code, input logic pflip, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit(~^code ^ pflip);
    send_bit(stop);
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
  endtask
  typedef struct {
    logic [7:0] code;
    logic pf;
    logic stop;
    int wr;
    int wa;
    int dat;
    int ptr;
    int err;
  } vec_t;
  vec_t v[13];
  initial begin
    int n0, e0, first, ecyc;
    v[0]  = '{8'h1C, 1'b0, 1'b1, 1, 0, 'h1C, 1, 0};
    v[1]  = '{8'hF0, 1'b0, 1'b1, 0, 0, 'h1C, 1, 0};
    v[2]  = '{8'h1C, 1'b0, 1'b1, 0, 0, 'h1C, 1, 0};
    v[3]  = '{8'h32, 1'b0, 1'b1, 1, 1, 'h32, 2, 0};
    v[4]  = '{8'hE0, 1'b0, 1'b1, 0, 0, 'h32, 2, 0};
    v[5]  = '{8'h75, 1'b0, 1'b1, 1, 2, 'h75, 3, 0};
    v[6]  = '{8'hE0, 1'b0, 1'b1, 0, 0, 'h75, 3, 0};
    v[7]  = '{8'hF0, 1'b0, 1'b1, 0, 0, 'h75, 3, 0};
    v[8]  = '{8'h75, 1'b0, 1'b1, 0, 0, 'h75, 3, 0};
    v[9]  = '{8'h1C, 1'b1, 1'b1, 0, 0, 'h75, 3, 1};
    v[10] = '{8'h1C, 1'b0, 1'b1, 1, 3, 'h1C, 4, 0};
    v[11] = '{8'h1C, 1'b0, 1'b0, 0, 0, 'h1C, 4, 1};
    v[12] = '{8'h66, 1'b0, 1'b1, 1, 4, 'h66, 5, 0};
    repeat (4) @(negedge clk);
    chk("reset ram_ena", int'(ram_ena), 0);
    chk("reset addr", int'(addr), 0);
    chk("reset data_in", int'(data_in), 0);
    chk("reset frame_err", int'(frame_err), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      n0 = nw;
      e0 = ne;
      send_frame(v[i].code, v[i].pf, v[i].stop);
      chk($sformatf("vec%0d writes", i), nw - n0, v[i].wr);
      chk($sformatf("vec%0d err cycles", i), ne - e0, v[i].err);
      chk($sformatf("vec%0d addr", i), int'(addr), v[i].ptr);
      chk($sformatf("vec%0d data_in", i), int'(data_in), v[i].dat);
      if (v[i].wr == 1) chk($sformatf("vec%0d write addr", i), wa, v[i].wa);
    end
    // Timeout: clock stops after 4 data bits; error pulse lands TIMEOUT cycles after the last edge strobe.
    n0 = nw;
    e0 = ne;
    first = 0;
    ecyc = 0;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2_data = 1'b1;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    for (int n = 1; n <= TO + 20; n++) begin
      @(negedge clk);
      if (n == H) ps2_clk = 1'b1;
      if (frame_err) begin
        ecyc++;
        if (first == 0) first = n;
      end
    end
    chk("timeout latency", first, TO + 2);
    chk("timeout pulse width", ecyc, 1);
    chk("timeout no write", nw - n0, 0);
    chk("timeout addr kept", int'(addr), 5);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("after timeout write addr", wa, 5);
    chk("after timeout addr", int'(addr), 6);
    // Reset mid-frame: outputs clear at once and nothing is written.
    n0 = nw;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst_n = 1'b0;
    #1;
    chk("midreset addr", int'(addr), 0);
    chk("midreset data_in", int'(data_in), 0);
    chk("midreset ram_ena", int'(ram_ena), 0);
    chk("midreset frame_err", int'(frame_err), 0);
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("midreset no write", nw - n0, 0);
    chk("midreset addr held", int'(addr), 0);
    // Wrap: 254 writes fill 0x00..0xFD, then 0xFE, then back to 0x00.
    n0 = nw;
    for (int i = 0; i < 254; i++) send_frame(8'h1C, 1'b0, 1'b1);
    chk("wrap count", nw - n0, 254);
    chk("wrap addr before", int'(addr), 'hFE);
    send_frame(8'h2A, 1'b0, 1'b1);
    chk("wrap write 255 addr", wa, 'hFE);
    chk("wrap data 255", int'(data_in), 'h2A);
    chk("wrap addr after", int'(addr), 0);
    send_frame(8'h29, 1'b0, 1'b1);
    chk("wrap write 256 addr", wa, 0);
    chk("wrap data 256", int'(data_in), 'h29);
    chk("flag addr never driven", ffseen, 0);
    chk("wena tracks ram_ena", wmis, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ps2_kb_ram_writer.md
Name: ps2_kb_ram_writer

Overview:
PS/2 keyboard receiver and write-port driver for the keyboard RAM buffer.
- Samples the raw PS/2 clock/data lines and deframes 11-bit device-to-host frames.
- Filters out break (key-release) sequences and extended prefixes.
- Writes each accepted make code into the keyboard RAM at a circular write pointer. The pointer never reaches the flag address; the RAM raises its own new-data flag at that address on every write.

Parameters:
WIDTH, 8, data width of RAM write bus (scan code width; must be 8)
DEPTH, 8, RAM address bits
TIMEOUT, 50000, clk cycles without a PS/2 falling edge before an in-progress frame is aborted (1 ms at 50 MHz)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ps2_clk  input  1  raw PS/2 clock line (asynchronous)
ps2_data  input  1  raw PS/2 data line (asynchronous)
ram_ena  output  1  RAM enable, high only during a write cycle
wena  output  1  RAM write enable, identical to ram_ena
addr  output  DEPTH  RAM address = current write pointer
data_in  output  WIDTH  scan code to be written
frame_err  output  1  one-cycle pulse on parity, stop or timeout error

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0; write pointer 0; FSM in IDLE; break and extended flags 0; bit counter 0; timeout counter 0.
- Synchroniser: ps2_clk and ps2_data each pass through 2 flops. A third flop on ps2_clk gives a falling-edge strobe fe = prev & ~cur. All frame logic acts only on fe. Input-to-fe latency is 3 clk.
- FSM states: IDLE, DATA, PARITY, STOP, WRITE.
- IDLE:
  - fe with data=0 -> DATA, bit counter cleared.
  - fe with data=1 is ignored as a glitch.
- DATA: on each fe, shift data in LSB first. After the 8th bit -> PARITY.
- PARITY: on fe, latch the parity bit -> STOP.
- STOP: on fe, check the frame.
  - Odd parity over 8 data bits + parity bit must hold, and stop bit must be 1.
  - Frame valid and the code is accepted (see filter) -> WRITE.
  - Frame valid and the code is filtered -> IDLE.
  - Frame invalid -> frame_err=1 for one cycle -> IDLE. The code is discarded and the break/extended flags are unchanged.
- Code filter (valid frames only):
  - 0xF0: set break flag, no write.
  - 0xE0: set extended flag, no write.
  - Any other code with break flag set: no write; clear both flags.
  - Any other code with break flag clear: accept; clear extended flag.
- WRITE (exactly one cycle):
  - ram_ena=wena=1; addr = write pointer; data_in = code.
  - Write pulse occurs on the clk cycle after the fe of the stop bit.
  - At the end of the cycle, pointer increments -> IDLE.
  - data_in holds the last written code until the next write.
- Pointer wrap: pointer runs 0 .. 2^DEPTH-2 and wraps from 2^DEPTH-2 to 0. addr never equals 2^DEPTH-1, the flag address.
- Timeout: the counter resets on every fe and in IDLE, and counts in DATA/PARITY/STOP.
  - Reaching TIMEOUT-1 -> frame_err pulse -> IDLE, partial frame dropped.
  - Timeout and fe in the same cycle: fe wins and the counter resets.
- WRITE is not interruptible. An fe arriving during WRITE is lost; a following frame starts with the next start bit after IDLE.
- Reset asserted mid-frame or during WRITE: immediate return to reset values; no write completes.

Test Plan:
- Single key 'A' (code 0x1C, parity 0, stop 1) at a 12.5 kHz PS/2 clock -> exactly one cycle ram_ena=wena=1, addr=0x00, data_in=0x1C; frame_err stays 0; pointer becomes 1.
- Press/release sequence 0x1C, 0xF0, 0x1C -> one write only (addr 0, 0x1C). Then 0x32 -> write at addr 1 with data 0x32.
- Extended sequence 0xE0, 0x75 -> one write of 0x75. Sequence 0xE0, 0xF0, 0x75 -> no write.
- Parity error: send 0x1C with parity bit 1 -> frame_err one-cycle pulse, no write, pointer unchanged. The next good frame writes at the unchanged address.
- Wrap: preload 254 writes with DEPTH=8 -> 255th write at addr 0xFE, next at 0x00. addr never equals 0xFF.
- Timeout and reset: stop ps2_clk after 4 data bits -> frame_err exactly TIMEOUT cycles after the last fe; a following full frame writes normally. Separately, assert rst_n low mid-frame -> outputs 0 immediately, no write.
